// File: rtl/fault_inject_chain.sv
// Receiving end of the fault-injection controller's serial link.
// Serial frames (mask LSB first, then CTRL[1], CTRL[0]) fill a shadow chain
// and commit to an active mask/control register on the last bit. A fault
// strobe then applies a stuck-at or timed bit-flip fault to the functional
// bus passing through this block.

// One bit of the functional bus: substitutes the stuck value or inverts the
// bit when this lane is selected by the mask.
module fault_inject_lane (
  input  logic func_in,
  input  logic mask,
  input  logic sa_en,
  input  logic tf_en,
  input  logic stuck_val,
  output logic func_out
);

  assign func_out = !mask ? func_in   :
                    sa_en ? stuck_val :
                    tf_en ? ~func_in  : func_in;

endmodule

module fault_inject_chain #(
  parameter int N_BITS   = 32,
  parameter int TF_WIDTH = 1,
  parameter int CNT_W    = $clog2(N_BITS+2)+1
) (
  input  logic              i_CLK_SYS,
  input  logic              i_RST_SYS,
  input  logic              i_SERIAL_IN,
  input  logic              i_EN_SR,
  input  logic              i_TFEn,
  input  logic              i_RST,
  input  logic [N_BITS-1:0] i_FUNC,
  output logic [N_BITS-1:0] o_FUNC,
  output logic [N_BITS-1:0] o_MASK,
  output logic [1:0]        o_CTRL,
  output logic [CNT_W-1:0]  o_BIT_CNT,
  output logic              o_FRAME_DONE,
  output logic              o_FAULT_ACTIVE
);

  // Shadow holds mask bits plus CTRL[1]; CTRL[0] arrives on the commit edge.
  localparam int SH_W = N_BITS + 1;
  localparam int TW_W = (TF_WIDTH > 1) ? $clog2(TF_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N_BITS + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_SA    = 2'd2;
  localparam logic [1:0] S_TF    = 2'd3;

  logic [1:0]        state;
  logic [SH_W-1:0]   shadow;
  logic [N_BITS-1:0] mask_q;
  logic [1:0]        ctrl_q;
  logic [CNT_W-1:0]  bit_cnt;
  logic [TW_W-1:0]   tw_cnt;
  logic              frame_done_q;
  logic              clr;
  logic              commit;
  logic              trig;
  logic              sa_en;
  logic              tf_en;

  assign clr    = i_RST_SYS | i_RST;
  assign commit = i_EN_SR && (bit_cnt == LAST_BIT);
  // A strobe only counts between frames with the link idle.
  assign trig   = i_TFEn && !i_EN_SR && (bit_cnt == '0);

  // Shadow chain fill and frame bit counter; idle gaps hold both.
  always_ff @(posedge i_CLK_SYS) begin
    if (clr) begin
      shadow  <= '0;
      bit_cnt <= '0;
    end else if (i_EN_SR) begin
      if (commit) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + CNT_W'(1);
        for (int i = 0; i < SH_W; i++)
          if (bit_cnt == CNT_W'(i)) shadow[i] <= i_SERIAL_IN;
      end
    end
  end

  // Active mask/control load and one-cycle frame-done pulse.
  always_ff @(posedge i_CLK_SYS) begin
    if (clr) begin
      mask_q       <= '0;
      ctrl_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= commit;
      if (commit) begin
        mask_q <= shadow[N_BITS-1:0];
        ctrl_q <= {shadow[N_BITS], i_SERIAL_IN};
      end
    end
  end

  // Fault state machine; a commit always drops any fault back to ARMED.
  always_ff @(posedge i_CLK_SYS) begin
    if (clr) begin
      state  <= S_IDLE;
      tw_cnt <= '0;
    end else if (commit) begin
      state  <= S_ARMED;
      tw_cnt <= '0;
    end else begin
      case (state)
        S_ARMED: begin
          if (trig) begin
            if (ctrl_q[1]) begin
              state  <= S_TF;
              tw_cnt <= TW_W'(TF_WIDTH - 1);
            end else begin
              state <= S_SA;
            end
          end
        end
        S_TF: begin
          if (tw_cnt == '0) state  <= S_ARMED;
          else              tw_cnt <= tw_cnt - TW_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Reset forces pass-through in the same cycle, before state clears.
  assign sa_en = (state == S_SA) && !clr;
  assign tf_en = (state == S_TF) && !clr;

  genvar g;
  generate
    for (g = 0; g < N_BITS; g++) begin : g_lane
      fault_inject_lane u_lane (
        .func_in   (i_FUNC[g]),
        .mask      (mask_q[g]),
        .sa_en     (sa_en),
        .tf_en     (tf_en),
        .stuck_val (ctrl_q[0]),
        .func_out  (o_FUNC[g])
      );
    end
  endgenerate

  assign o_MASK         = mask_q;
  assign o_CTRL         = ctrl_q;
  assign o_BIT_CNT      = bit_cnt;
  assign o_FRAME_DONE   = frame_done_q;
  assign o_FAULT_ACTIVE = (state == S_SA) || (state == S_TF);

endmodule

// File: tb/tb_fault_inject_chain.sv
// Directed bench for fault_inject_chain: N_BITS=8 with a 3-cycle transient
// instance and a 20-cycle transient instance sharing the same stimulus.
module tb_fault_inject_chain;

  logic       clk = 1'b0;
  logic       rst_sys, serial, en_sr, tfen, rst_c;
  logic [7:0] func;

  logic [7:0] o_func, o_mask, l_func, l_mask;
  logic [1:0] o_ctrl, l_ctrl;
  logic [4:0] o_cnt, l_cnt;
  logic       o_done, o_act, l_done, l_act;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fault_inject_chain #(.N_BITS(8), .TF_WIDTH(3)) dut (
    .i_CLK_SYS(clk), .i_RST_SYS(rst_sys), .i_SERIAL_IN(serial), .i_EN_SR(en_sr),
    .i_TFEn(tfen), .i_RST(rst_c), .i_FUNC(func), .o_FUNC(o_func), .o_MASK(o_mask),
    .o_CTRL(o_ctrl), .o_BIT_CNT(o_cnt), .o_FRAME_DONE(o_done), .o_FAULT_ACTIVE(o_act)
  );

  fault_inject_chain #(.N_BITS(8), .TF_WIDTH(20)) dut_long (
    .i_CLK_SYS(clk), .i_RST_SYS(rst_sys), .i_SERIAL_IN(serial), .i_EN_SR(en_sr),
    .i_TFEn(tfen), .i_RST(rst_c), .i_FUNC(func), .o_FUNC(l_func), .o_MASK(l_mask),
    .o_CTRL(l_ctrl), .o_BIT_CNT(l_cnt), .o_FRAME_DONE(l_done), .o_FAULT_ACTIVE(l_act)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame bit i is fr[i]: mask[7:0], then CTRL[1], then CTRL[0].
  task automatic shift_bits(input logic [9:0] fr, input int from, input int cnt);
    for (int i = from; i < from + cnt; i++) begin
      en_sr  = 1'b1;
      serial = fr[i];
      tick();
    end
    en_sr  = 1'b0;
    serial = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] m, input logic [1:0] c);
    shift_bits({c[0], c[1], m}, 0, 10);
  endtask

  task automatic pulse();
    tfen = 1'b1;
    tick();
    tfen = 1'b0;
  endtask

  logic [9:0] fr;

  initial begin
    rst_sys = 1'b1; rst_c = 1'b0; en_sr = 1'b0; serial = 1'b0; tfen = 1'b0;
    func = 8'h3C;
    tick(); tick();

    // reset state
    chk("rst_func", o_func, 8'h3C);
    chk("rst_mask", o_mask, 8'h00);
    chk("rst_ctrl", o_ctrl, 2'b00);
    chk("rst_cnt", o_cnt, 5'd0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_act", o_act, 1'b0);
    rst_sys = 1'b0;
    tick();

    // stuck-at 0 on mask A5
    func = 8'hFF;
    send_frame(8'hA5, 2'b00);
    chk("sa_done", o_done, 1'b1);
    chk("sa_mask", o_mask, 8'hA5);
    chk("sa_ctrl", o_ctrl, 2'b00);
    chk("sa_cnt0", o_cnt, 5'd0);
    chk("sa_armed_func", o_func, 8'hFF);
    tick();
    chk("sa_done_clr", o_done, 1'b0);
    pulse();
    chk("sa_act", o_act, 1'b1);
    chk("sa_func", o_func, 8'h5A);
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("sa_hold", o_func, 8'h5A);
    end
    func = 8'h0F;
    #1;
    chk("sa_func2", o_func, 8'h0A);
    pulse();
    chk("sa_retrig", o_func, 8'h0A);
    chk("sa_act2", o_act, 1'b1);

    // transient flip of mask 0F for 3 cycles; commit clears stuck-at
    func = 8'h00;
    send_frame(8'h0F, 2'b10);
    chk("tf_done", o_done, 1'b1);
    chk("tf_commit_act", o_act, 1'b0);
    chk("tf_commit_func", o_func, 8'h00);
    chk("tf_ctrl", o_ctrl, 2'b10);
    tick();
    pulse();
    chk("tf_c1", o_func, 8'h0F);
    chk("tf_a1", o_act, 1'b1);
    tfen = 1'b1;
    tick();
    tfen = 1'b0;
    chk("tf_c2", o_func, 8'h0F);
    chk("tf_a2", o_act, 1'b1);
    tick();
    chk("tf_c3", o_func, 8'h0F);
    chk("tf_a3", o_act, 1'b1);
    tick();
    chk("tf_c4", o_func, 8'h00);
    chk("tf_a4", o_act, 1'b0);
    tick();
    chk("tf_c5", o_func, 8'h00);
    chk("tf_a5", o_act, 1'b0);

    // split frame: 4 bits, 20 idle cycles, 6 bits
    fr = {1'b1, 1'b0, 8'h3C};
    shift_bits(fr, 0, 4);
    chk("split_cnt4", o_cnt, 5'd4);
    repeat (20) tick();
    chk("split_hold", o_cnt, 5'd4);
    chk("split_nodone", o_done, 1'b0);
    chk("split_oldmask", o_mask, 8'h0F);
    shift_bits(fr, 4, 5);
    chk("split_cnt9", o_cnt, 5'd9);
    chk("split_nodone9", o_done, 1'b0);
    shift_bits(fr, 9, 1);
    chk("split_done", o_done, 1'b1);
    chk("split_mask", o_mask, 8'h3C);
    chk("split_ctrl", o_ctrl, 2'b01);
    chk("split_cnt0", o_cnt, 5'd0);

    // strobe ignored when idle, with shift enable high, or mid-frame
    rst_sys = 1'b1;
    tick();
    rst_sys = 1'b0;
    chk("idle_mask", o_mask, 8'h00);
    func = 8'h55;
    pulse();
    chk("idle_act", o_act, 1'b0);
    chk("idle_func", o_func, 8'h55);
    send_frame(8'hFF, 2'b00);
    tick();
    fr = {1'b1, 1'b0, 8'hFF};
    tfen = 1'b1;
    shift_bits(fr, 0, 1);
    tfen = 1'b0;
    chk("en_tfen_act", o_act, 1'b0);
    chk("en_tfen_func", o_func, 8'h55);
    shift_bits(fr, 1, 2);
    chk("mid_cnt3", o_cnt, 5'd3);
    pulse();
    chk("mid_act", o_act, 1'b0);
    chk("mid_func", o_func, 8'h55);
    tick();
    chk("mid_act2", o_act, 1'b0);
    shift_bits(fr, 3, 7);
    chk("mid_mask", o_mask, 8'hFF);
    chk("mid_ctrl", o_ctrl, 2'b01);

    // stuck-at 1 then chain clear
    func = 8'h00;
    tick();
    pulse();
    chk("sa1_act", o_act, 1'b1);
    chk("sa1_func", o_func, 8'hFF);
    rst_c = 1'b1;
    #1;
    chk("clr_same_cycle", o_func, 8'h00);
    tick();
    rst_c = 1'b0;
    chk("clr_func", o_func, 8'h00);
    chk("clr_mask", o_mask, 8'h00);
    chk("clr_ctrl", o_ctrl, 2'b00);
    chk("clr_act", o_act, 1'b0);
    chk("clr_cnt", o_cnt, 5'd0);
    pulse();
    chk("clr_idle_act", o_act, 1'b0);

    // commit during transient drops fault; next strobe uses new frame
    send_frame(8'h0F, 2'b10);
    tick();
    pulse();
    chk("long_act1", l_act, 1'b1);
    chk("long_func1", l_func, 8'h0F);
    func = 8'h33;
    fr = {1'b0, 1'b1, 8'hF0};
    shift_bits(fr, 0, 5);
    chk("long_mid_act", l_act, 1'b1);
    chk("long_mid_func", l_func, 8'h3C);
    shift_bits(fr, 5, 5);
    chk("long_commit_done", l_done, 1'b1);
    chk("long_commit_act", l_act, 1'b0);
    chk("long_commit_func", l_func, 8'h33);
    chk("long_commit_mask", l_mask, 8'hF0);
    tick();
    pulse();
    chk("long_new_act", l_act, 1'b1);
    chk("long_new_func", l_func, 8'hC3);
    repeat (19) tick();
    chk("long_last_act", l_act, 1'b1);
    chk("long_last_func", l_func, 8'hC3);
    tick();
    chk("long_end_act", l_act, 1'b0);
    chk("long_end_func", l_func, 8'h33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
